// File: rtl/mprj_bram_arbiter.sv
// Round-robin arbiter sharing the single-port user-project BRAM between the
// Wishbone slave path (port 0) and an internal master (port 1).
module mprj_bram_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter int          DELAYS    = 10,
    parameter logic [7:0]  BASE_ADDR = 8'h38
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_sel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,

    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,

    output logic              busy_o,
    output logic [1:0]        dbg_state
);

    // Handshake: port 0 is a classic Wishbone slave (request = cyc & stb in
    // the BASE_ADDR window, one-cycle ack, cyc drop aborts); port 1 holds
    // m1_req until its one-cycle m1_ack, read data valid with the ack.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        last_grant;
    logic        gnt_id;
    logic        lat_we;

    logic        p0_req;
    logic        grant_id;
    logic        p0_abort;

    // Address bits between the word index and the window byte only alias.
    logic        unused_adr_bits;
    assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    always_comb begin
        p0_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR);
        grant_id = (p0_req && m1_req) ? ~last_grant : ~p0_req;
        p0_abort = (gnt_id == 1'b0) && !wbs_cyc_i;
    end

    assign busy_o    = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            lat_we     <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'd0;
            m1_ack     <= 1'b0;
            m1_rdata   <= 32'd0;
            bram_en    <= 1'b0;
            bram_we    <= 4'd0;
            bram_addr  <= '0;
            bram_wdata <= 32'd0;
        end else begin
            // Pulsed outputs default low; read data is only valid with ack.
            wbs_ack_o <= 1'b0;
            m1_ack    <= 1'b0;
            wbs_dat_o <= 32'd0;
            m1_rdata  <= 32'd0;
            bram_en   <= 1'b0;
            bram_we   <= 4'd0;

            case (state)
                IDLE: begin
                    if (p0_req || m1_req) begin
                        gnt_id     <= grant_id;
                        last_grant <= grant_id;
                        bram_en    <= 1'b1;
                        state      <= ISSUE;
                        if (grant_id == 1'b0) begin
                            lat_we     <= wbs_we_i;
                            bram_we    <= wbs_we_i ? wbs_sel_i : 4'd0;
                            bram_addr  <= wbs_adr_i[ADDR_W+1:2];
                            bram_wdata <= wbs_dat_i;
                        end else begin
                            lat_we     <= m1_we;
                            bram_we    <= m1_we ? m1_sel : 4'd0;
                            bram_addr  <= m1_addr;
                            bram_wdata <= m1_wdata;
                        end
                    end
                end

                ISSUE: begin
                    if (p0_abort) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= 8'(DELAYS);
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (p0_abort) begin
                        wait_cnt <= 8'd0;
                        state    <= IDLE;
                    end else if (wait_cnt <= 8'd1) begin
                        // Ack and data are registered here so they appear
                        // together during RESP.
                        wait_cnt <= 8'd0;
                        state    <= RESP;
                        if (gnt_id == 1'b0) begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= lat_we ? 32'd0 : bram_rdata;
                        end else begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= lat_we ? 32'd0 : bram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_bram_arbiter.sv
// Self-checking bench for mprj_bram_arbiter: a behavioural BRAM plus a
// reference memory/arbitration model drive immediate-assertion checks.
module tb_mprj_bram_arbiter;

    localparam int         ADDR_W    = 10;
    localparam int         DELAYS    = 10;
    localparam logic [7:0] BASE_ADDR = 8'h38;

    logic              clk = 1'b0;
    logic              wb_rst_i;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              m1_req, m1_we;
    logic [3:0]        m1_sel;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_ack;
    logic [31:0]       m1_rdata;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata, bram_rdata;
    logic              busy_o;
    logic [1:0]        dbg_state;
    logic              mem_clr;

    mprj_bram_arbiter #(.ADDR_W(ADDR_W), .DELAYS(DELAYS), .BASE_ADDR(BASE_ADDR)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .busy_o(busy_o), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural BRAM (one-cycle read) ----------------
    logic [31:0] bram_mem [1024];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) bram_mem[i] <= 32'd0;
            bram_rdata <= 32'd0;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_rdata <= bram_mem[bram_addr];
        end
    end

    // ---------------- event monitor ----------------
    int en_count = 0, wb_ack_count = 0, m1_ack_count = 0, overlap_count = 0;
    always @(negedge clk) begin
        if (bram_en)              en_count++;
        if (wbs_ack_o)            wb_ack_count++;
        if (m1_ack)               m1_ack_count++;
        if (wbs_ack_o && m1_ack)  overlap_count++;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_q [$];
    int          exp_en = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one complete transaction on either port ----------------
    task automatic do_xfer(input int port, input logic we, input logic [3:0] sel,
                           input logic [ADDR_W-1:0] word, input logic [31:0] data,
                           input logic [11:0] alias_bits, input string tag,
                           output logic [31:0] rd);
        int          n;
        int          en_cyc;
        logic        done;
        logic [3:0]  en_we;
        logic [ADDR_W-1:0] en_addr;
        logic [31:0] en_wdata;
        logic [31:0] exp_rd;
        exp_rd = we ? 32'd0 : ref_mem[word];
        if (port == 0) begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
            wbs_adr_i = {BASE_ADDR, alias_bits, word, 2'b00}; wbs_dat_i = data;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_sel = sel; m1_addr = word; m1_wdata = data;
        end
        n = 0; en_cyc = -1; done = 1'b0;
        en_we = '0; en_addr = '0; en_wdata = '0;
        while (n < 100 && !done) begin
            @(negedge clk);
            n++;
            if (bram_en && en_cyc < 0) begin
                en_cyc = n; en_we = bram_we; en_addr = bram_addr; en_wdata = bram_wdata;
            end
            if ((port == 0) ? wbs_ack_o : m1_ack) done = 1'b1;
        end
        rd = (port == 0) ? wbs_dat_o : m1_rdata;
        if (port == 0) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
        else m1_req = 1'b0;
        exp_en++;
        check($sformatf("%s_latency", tag), n, DELAYS + 2);
        check($sformatf("%s_en_cycle", tag), en_cyc, 1);
        check($sformatf("%s_bram_addr", tag), 32'(en_addr), 32'(word));
        check($sformatf("%s_bram_we", tag), 32'(en_we), we ? 32'(sel) : 32'd0);
        if (we) check($sformatf("%s_bram_wdata", tag), en_wdata, data);
        check($sformatf("%s_rdata", tag), rd, exp_rd);
        if (we) ref_mem[word] = merge(ref_mem[word], data, sel);
        @(negedge clk);
        check($sformatf("%s_data_clear", tag), (port == 0) ? wbs_dat_o : m1_rdata, 32'd0);
        check($sformatf("%s_ack_clear", tag), 32'(wbs_ack_o | m1_ack), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    logic [ADDR_W-1:0] pool [8];
    logic [ADDR_W-1:0] wa, wb, a0, a1;
    logic [31:0]       rd, wdat;
    int                cyc, acks, prev_ack, got, snap_en, snap_wb, snap_m1;
    logic              last;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 8; i++) pool[i] = ADDR_W'($urandom_range(0, 1023));
        wb_rst_i = 1'b1; mem_clr = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_bram_en", 32'(bram_en), 0);
        check("rst_bram_we", 32'(bram_we), 0);
        check("rst_bram_addr", 32'(bram_addr), 0);
        check("rst_acks", 32'(wbs_ack_o | m1_ack), 0);
        check("rst_wbs_dat", wbs_dat_o, 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_state", 32'(dbg_state), 0);
        wb_rst_i = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        // Basic WB write then read of 0x3800_0010
        do_xfer(0, 1'b1, 4'hF, 10'd4, 32'hDEADBEEF, 12'h000, "wb_wr", rd);
        do_xfer(0, 1'b0, 4'hF, 10'd4, 32'h0, 12'h000, "wb_rd", rd);
        check("wb_rd_deadbeef", rd, 32'hDEADBEEF);

        // Randomised mixed traffic, aliased WB addresses, random gaps
        for (int i = 0; i < 24; i++) begin
            wa = pool[$urandom_range(0, 7)];
            do_xfer(int'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), 4'($urandom_range(1, 15)),
                    wa, $urandom, 12'($urandom), $sformatf("rnd%0d", i), rd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Leave last_grant pointing at port 0, then reset: a tie must still go to port 0
        do_xfer(0, 1'b0, 4'hF, pool[0], 32'h0, 12'h000, "pre_rr", rd);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;

        // Round robin with both ports continuously requesting
        last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            last = ~last;
            exp_q.push_back(32'(last));
        end
        a0 = pool[$urandom_range(0, 7)];
        a1 = pool[$urandom_range(0, 7)];
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_adr_i = {BASE_ADDR, 12'h0, a0, 2'b00};
        m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_addr = a1;
        cyc = 0; acks = 0; prev_ack = 0;
        while (acks < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (wbs_ack_o || m1_ack) begin
                got = m1_ack ? 1 : 0;
                check($sformatf("rr_order%0d", acks), got, exp_q.pop_front());
                check($sformatf("rr_period%0d", acks), cyc - prev_ack,
                      (acks == 0) ? DELAYS + 2 : DELAYS + 3);
                if (got == 0) begin
                    check($sformatf("rr_data%0d", acks), wbs_dat_o, ref_mem[a0]);
                    a0 = pool[$urandom_range(0, 7)];
                    wbs_adr_i = {BASE_ADDR, 12'h0, a0, 2'b00};
                end else begin
                    check($sformatf("rr_data%0d", acks), m1_rdata, ref_mem[a1]);
                    a1 = pool[$urandom_range(0, 7)];
                    m1_addr = a1;
                end
                acks++;
                exp_en++;
                prev_ack = cyc;
                if (acks == 4) begin
                    wbs_cyc_i = 0; wbs_stb_i = 0; m1_req = 0;
                end
            end
        end
        check("rr_ack_count", acks, 4);
        wbs_cyc_i = 0; wbs_stb_i = 0; m1_req = 0;
        @(negedge clk);

        // Out-of-window WB access is ignored, port 1 still served
        snap_en = en_count; snap_wb = wb_ack_count;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0000; wbs_dat_i = $urandom;
        repeat (50) @(negedge clk);
        check("oow_no_en", en_count - snap_en, 0);
        check("oow_no_ack", wb_ack_count - snap_wb, 0);
        check("oow_busy", 32'(busy_o), 0);
        do_xfer(1, 1'b0, 4'hF, pool[3], 32'h0, 12'h000, "oow_m1", rd);
        check("oow_no_ack_after", wb_ack_count - snap_wb, 0);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;

        // WB read aborted by dropping cyc during WAIT; pending m1 read follows
        wa = pool[$urandom_range(0, 7)];
        wb = pool[$urandom_range(0, 7)];
        snap_wb = wb_ack_count;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_adr_i = {BASE_ADDR, 12'h0, wa, 2'b00};
        cyc = 0;
        repeat (5) begin @(negedge clk); cyc++; end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_addr = wb; m1_wdata = $urandom;
        @(negedge clk); cyc++;
        check("abort_state_idle", 32'(dbg_state), 0);
        check("abort_busy_low", 32'(busy_o), 0);
        @(negedge clk); cyc++;
        check("abort_m1_en", 32'(bram_en), 1);
        check("abort_m1_addr", 32'(bram_addr), 32'(wb));
        while (!m1_ack && cyc < 100) begin @(negedge clk); cyc++; end
        check("abort_m1_ack_cycle", cyc, 5 + 1 + DELAYS + 2);
        check("abort_m1_rdata", m1_rdata, ref_mem[wb]);
        m1_req = 0;
        exp_en += 2;
        @(negedge clk);
        check("abort_no_wb_ack", wb_ack_count - snap_wb, 0);

        // Reset during WAIT of an m1 read
        wa = pool[$urandom_range(0, 7)] | 10'd1;
        snap_m1 = m1_ack_count;
        m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_addr = wa; m1_wdata = $urandom | 32'd1;
        repeat (5) @(negedge clk);
        wb_rst_i = 1; m1_req = 0;
        @(negedge clk);
        check("mrst_bram_en", 32'(bram_en), 0);
        check("mrst_bram_we", 32'(bram_we), 0);
        check("mrst_bram_addr", 32'(bram_addr), 0);
        check("mrst_bram_wdata", bram_wdata, 0);
        check("mrst_outputs", {wbs_dat_o | m1_rdata}, 0);
        check("mrst_acks_busy", 32'({wbs_ack_o, m1_ack, busy_o}), 0);
        wb_rst_i = 0;
        exp_en++;
        do_xfer(1, 1'b0, 4'hF, wa, 32'h0, 12'h000, "mrst_rd", rd);
        check("mrst_single_ack", m1_ack_count - snap_m1, 1);

        // Byte-enable write over an all-ones word
        do_xfer(0, 1'b1, 4'hF, 10'd7, 32'hFFFF_FFFF, 12'h000, "be_fill", rd);
        wdat = $urandom;
        do_xfer(1, 1'b1, 4'b0011, 10'd7, wdat, 12'h000, "be_wr", rd);
        do_xfer(0, 1'b0, 4'hF, 10'd7, 32'h0, 12'h000, "be_rd", rd);
        check("be_rd_high", 32'(rd[31:16]), 32'h0000_FFFF);
        check("be_rd_low", 32'(rd[15:0]), 32'(wdat[15:0]));

        // Global invariants
        repeat (3) @(negedge clk);
        check("en_pulse_count", en_count, exp_en);
        check("ack_overlap", overlap_count, 0);
        check("rr_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mprj_bram_arbiter.md
Name: mprj_bram_arbiter

Overview:
Arbitrates the single-port user-project BRAM (mprjram, 0x3800_0000 window) between two requesters.
- Port 0: the management core's Wishbone slave path.
- Port 1: an internal master such as the UART/matmul data engine.

Each winning request is sequenced as one BRAM access: enable pulse, programmable wait, one-cycle ack. Round-robin ordering ensures firmware running matmul() from BRAM cannot be starved by the engine, and vice versa.

Parameters:
- ADDR_W, 10, BRAM word-address width (1K words = 4 KB).
- DELAYS, 10, wait cycles between BRAM enable and ack; legal range 1..255; must be >= BRAM read latency.
- BASE_ADDR, 8'h38, required value of wbs_adr_i[31:24] for port 0 to be served.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte selects.
- wbs_adr_i  in  32  Wishbone byte address.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_ack_o  out  1  Wishbone ack.
- wbs_dat_o  out  32  Wishbone read data.
- m1_req  in  1  port-1 request; held until m1_ack.
- m1_we  in  1  port-1 write.
- m1_sel  in  4  port-1 byte enables.
- m1_addr  in  ADDR_W  port-1 word address.
- m1_wdata  in  32  port-1 write data.
- m1_ack  out  1  port-1 completion pulse.
- m1_rdata  out  32  port-1 read data, valid with m1_ack.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  ADDR_W  BRAM word address.
- bram_wdata  out  32  BRAM write data.
- bram_rdata  in  32  BRAM read data.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0; last_grant=1, so port 0 wins the first tie. A reset mid-transaction aborts it with no ack. A BRAM write already issued is not undone.
- Port 0 request: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE_ADDR). Requests outside the window are ignored; no ack is generated.
- Port 0 word address: wbs_adr_i[ADDR_W+1:2]. Upper bits within the window alias.
- FSM IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the port != last_grant.
  - On grant: latch addr, wdata, we, sel and the granted id; update last_grant; go to ISSUE.
- FSM ISSUE (1 cycle): bram_en=1; bram_we = we ? sel : 4'b0; bram_addr and bram_wdata from latches. Load counter with DELAYS; go to WAIT.
- FSM WAIT: bram_en=0, bram_we=0. Decrement counter; when it reaches 1, capture bram_rdata into a holding register and go to RESP.
- FSM RESP (1 cycle): pulse the granted port's ack. wbs_dat_o/m1_rdata hold the captured data while ack=1. For writes the data output is don't-care but driven 0. Go to IDLE.
- Latency: request seen in IDLE at cycle 0 → ack at cycle DELAYS+2. Minimum back-to-back period is DELAYS+3 cycles.
- Abort: if a port-0 grant sees wbs_cyc_i=0 during ISSUE or WAIT, return to IDLE with no ack. last_grant stays updated.
- Port-1 protocol: dropping m1_req before ack is illegal; behaviour is unspecified.
- Read data outputs return to 0 the cycle after ack.
- A request arriving during a transaction waits. Arbitration happens only in IDLE.
- Both acks are never high in the same cycle.
- bram_en is high for exactly one cycle per transaction.

Test Plan:
- Reset, then WB write 0xDEADBEEF to 0x3800_0010, sel=4'hF → bram_en with bram_addr=4 and bram_we=4'hF at cycle 1; wbs_ack_o at cycle 12 (DELAYS=10). A following WB read of the same address returns 0xDEADBEEF with ack 12 cycles after request.
- WB and m1 requests both asserted continuously for 4 transactions from reset → grant order 0,1,0,1. Acks never overlap; each transaction takes 13 cycles.
- WB access to 0x3000_0000 → no bram_en and no wbs_ack_o for 50 cycles. A concurrent m1 request is still served normally.
- WB read granted, wbs_cyc_i dropped at cycle 5 → state back to IDLE next cycle, no ack. A pending m1 request is granted immediately after.
- wb_rst_i pulsed during WAIT of an m1 read → all outputs 0 the next cycle, no m1_ack. After release, the re-asserted m1 read completes in 12 cycles.
- m1 writes with sel=4'b0011 to word 7 after a prior 0xFFFFFFFF fill → bram_we=4'b0011. A read of word 7 returns 0xFFFF_xxxx, with the low half equal to m1_wdata[15:0].
